// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and baud divider helper
`timescale 1ns/1ps
package uart_pkg;

    localparam int OVS_TICKS = 16;
    localparam int MID_TICK  = 8;
    localparam int DATA_W    = 8;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    // Rounded clk/(baud*ovs), never below one clock per tick.
    function automatic int tick_div(input int clk_freq, input int baud, input int ovs);
        int den;
        int d;
        den = baud * ovs;
        d   = (clk_freq + den / 2) / den;
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - free-running divider producing the shared oversampling tick
`timescale 1ns/1ps
module uart_baud_gen #(
    parameter int TICK_DIV = 651
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic b_tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign b_tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart.sv
// rtl/uart.sv - full-duplex 8N1 UART; define UART_FRAME_ERR_EN to add stop-bit checking
`timescale 1ns/1ps
module uart
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int OVS      = OVS_TICKS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              rx,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_busy,
    output logic              rx_done
`ifdef UART_FRAME_ERR_EN
    ,
    output logic              rx_frame_err
`endif
);

    localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD, OVS);
    localparam int TW       = $clog2(OVS);
    localparam int BW       = $clog2(DATA_W);
    localparam int MID      = OVS * MID_TICK / OVS_TICKS;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
    localparam logic [TW-1:0] MID_LAST  = TW'(MID - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

    logic b_tick;

    uart_baud_gen #(.TICK_DIV(TICK_DIV)) u_baud_gen (
        .clk_i   (clk),
        .rst_i   (rst),
        .b_tick_o(b_tick)
    );

    tx_state_e         tx_state_q;
    logic              tx_q;
    logic              tx_busy_q;
    logic              tx_done_q;
    logic [DATA_W-1:0] tx_shift_q;
    logic [TW-1:0]     tx_tick_q;
    logic [BW-1:0]     tx_bit_q;

    // The line value is registered one step ahead so tx never glitches between bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_shift_q <= '0;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
        end else begin
            tx_done_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_start) begin
                        tx_shift_q <= tx_data;
                        tx_busy_q  <= 1'b1;
                        tx_q       <= 1'b0;
                        tx_tick_q  <= '0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (b_tick) begin
                        if (tx_tick_q == TICK_LAST) begin
                            tx_tick_q  <= '0;
                            tx_bit_q   <= '0;
                            tx_q       <= tx_shift_q[0];
                            tx_state_q <= TX_DATA;
                        end else begin
                            tx_tick_q <= tx_tick_q + TW'(1);
                        end
                    end
                end
                TX_DATA: begin
                    if (b_tick) begin
                        if (tx_tick_q == TICK_LAST) begin
                            tx_tick_q <= '0;
                            if (tx_bit_q == BIT_LAST) begin
                                tx_q       <= 1'b1;
                                tx_state_q <= TX_STOP;
                            end else begin
                                tx_shift_q <= tx_shift_q >> 1;
                                tx_q       <= tx_shift_q[1];
                                tx_bit_q   <= tx_bit_q + BW'(1);
                            end
                        end else begin
                            tx_tick_q <= tx_tick_q + TW'(1);
                        end
                    end
                end
                TX_STOP: begin
                    if (b_tick) begin
                        if (tx_tick_q == TICK_LAST) begin
                            tx_tick_q  <= '0;
                            tx_done_q  <= 1'b1;
                            tx_busy_q  <= 1'b0;
                            tx_state_q <= TX_IDLE;
                        end else begin
                            tx_tick_q <= tx_tick_q + TW'(1);
                        end
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign tx      = tx_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;

    rx_state_e         rx_state_q;
    logic              rx_meta_q;
    logic              rx_sync_q;
    logic              rx_busy_q;
    logic              rx_done_q;
    logic [DATA_W-1:0] rx_data_q;
    logic [DATA_W-1:0] rx_shift_q;
    logic [TW-1:0]     rx_tick_q;
    logic [BW-1:0]     rx_bit_q;
`ifdef UART_FRAME_ERR_EN
    logic              rx_ferr_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Sampling is anchored to the mid-bit point found during the start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_busy_q  <= 1'b0;
            rx_done_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_shift_q <= '0;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
`ifdef UART_FRAME_ERR_EN
            rx_ferr_q  <= 1'b0;
`endif
        end else begin
            rx_done_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_sync_q) begin
                        rx_busy_q  <= 1'b1;
                        rx_tick_q  <= '0;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (b_tick) begin
                        if (rx_tick_q == MID_LAST) begin
                            rx_tick_q <= '0;
                            if (rx_sync_q) begin
                                rx_busy_q  <= 1'b0;
                                rx_state_q <= RX_IDLE;
                            end else begin
                                rx_bit_q   <= '0;
                                rx_state_q <= RX_DATA;
`ifdef UART_FRAME_ERR_EN
                                rx_ferr_q  <= 1'b0;
`endif
                            end
                        end else begin
                            rx_tick_q <= rx_tick_q + TW'(1);
                        end
                    end
                end
                RX_DATA: begin
                    if (b_tick) begin
                        if (rx_tick_q == TICK_LAST) begin
                            rx_tick_q  <= '0;
                            rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_W-1:1]};
                            if (rx_bit_q == BIT_LAST) begin
                                rx_state_q <= RX_STOP;
                            end else begin
                                rx_bit_q <= rx_bit_q + BW'(1);
                            end
                        end else begin
                            rx_tick_q <= rx_tick_q + TW'(1);
                        end
                    end
                end
                RX_STOP: begin
                    if (b_tick) begin
                        if (rx_tick_q == TICK_LAST) begin
                            rx_tick_q  <= '0;
                            rx_busy_q  <= 1'b0;
                            rx_state_q <= RX_IDLE;
`ifdef UART_FRAME_ERR_EN
                            if (rx_sync_q) begin
                                rx_data_q <= rx_shift_q;
                                rx_done_q <= 1'b1;
                            end else begin
                                rx_ferr_q <= 1'b1;
                            end
`else
                            rx_data_q <= rx_shift_q;
                            rx_done_q <= 1'b1;
`endif
                        end else begin
                            rx_tick_q <= rx_tick_q + TW'(1);
                        end
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_data = rx_data_q;
    assign rx_busy = rx_busy_q;
    assign rx_done = rx_done_q;
`ifdef UART_FRAME_ERR_EN
    assign rx_frame_err = rx_ferr_q;
`endif

endmodule

// File: tb/tb_uart.sv
// tb/tb_uart.sv - scoreboard bench for uart (RX, loopback echo, busy ignore, glitch, stop-bit error)
`timescale 1ns/1ps
module tb_uart;

    localparam int CLK_FREQ = 100_000_000;
    localparam int BAUD     = 1_562_500;
    localparam int OVS      = 16;
    localparam int BIT_CLKS = 64;
    localparam int BIT_NS   = 640;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tb_tx_start = 1'b0;
    logic [7:0] tb_tx_data = 8'h00;
    logic       rx = 1'b1;
    logic       loop_en = 1'b0;
    logic       tx, tx_busy, tx_done, rx_busy, rx_done;
    logic [7:0] rx_data;
`ifdef UART_FRAME_ERR_EN
    logic       rx_frame_err;
`endif

    wire       dut_tx_start = loop_en ? rx_done : tb_tx_start;
    wire [7:0] dut_tx_data  = loop_en ? rx_data : tb_tx_data;

    uart #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVS(OVS)) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_start(dut_tx_start),
        .tx_data (dut_tx_data),
        .rx      (rx),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done),
        .rx_data (rx_data),
        .rx_busy (rx_busy),
        .rx_done (rx_done)
`ifdef UART_FRAME_ERR_EN
        ,
        .rx_frame_err(rx_frame_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rx_done_cnt = 0;
    int tx_done_cnt = 0;
    int rx_done_cyc = 0;
    int tx_done_cyc = 0;
    int c0 = 0;
    int nt = 0;
    logic [7:0] rxq[$];
    logic [7:0] txq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_done) begin
            rx_done_cnt++;
            rx_done_cyc = cyc;
            if (rxq.size() == 0) check("rx_unexpected", rxq.size(), 1);
            else check("rx_data", rx_data, rxq.pop_front());
        end
        if (tx_done) begin
            tx_done_cnt++;
            tx_done_cyc = cyc;
        end
    end

    initial begin : tx_decoder
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                repeat (BIT_CLKS / 2) @(negedge clk);
                check("tx_start_bit", tx, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CLKS) @(negedge clk);
                    b[i] = tx;
                end
                repeat (BIT_CLKS) @(negedge clk);
                check("tx_stop_bit", tx, 1);
                if (txq.size() == 0) check("tx_unexpected", txq.size(), 1);
                else check("tx_byte", b, txq.pop_front());
            end
        end
    end

    task automatic send_rx(input logic [7:0] b, input logic stop_bit, input bit chk_busy);
        @(negedge clk);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(BIT_NS / 2);
            if (chk_busy) check("rx_busy_frame", rx_busy, 1);
            #(BIT_NS / 2);
        end
        if (stop_bit) begin
            rx = 1'b1;
            #(BIT_NS);
        end else begin
            rx = 1'b0;
            #(BIT_NS * 3 / 4);
            rx = 1'b1;
            #(BIT_NS / 4);
        end
    endtask

    task automatic wait_tx_done(input int start, input int budget);
        int n;
        n = 0;
        while (tx_done_cnt == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("tx_done_seen", tx_done_cnt, start + 1);
    endtask

    initial begin : watchdog
        #(500_000);
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #7;
        check("rst_tx", tx, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_busy", rx_busy, 0);
        check("rst_rx_done", rx_done, 0);
        check("rst_b_tick", dut.b_tick, 0);
`ifdef UART_FRAME_ERR_EN
        check("rst_frame_err", rx_frame_err, 0);
`endif
        #13;
        rst = 1'b0;

        nt = 0;
        repeat (40) begin
            @(negedge clk);
            if (dut.b_tick) nt++;
        end
        check("b_tick_rate", nt, 10);

        // single received byte
        c0 = rx_done_cnt;
        rxq.push_back(8'h30);
        send_rx(8'h30, 1'b1, 1'b1);
        check("rx_done_once", rx_done_cnt, c0 + 1);
        check("rx_busy_idle", rx_busy, 0);
        check("rx_data_hold", rx_data, 8'h30);

        // loopback echo, twice
        loop_en = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            rxq.push_back(8'h30);
            txq.push_back(8'h30);
            c0 = tx_done_cnt;
            send_rx(8'h30, 1'b1, 1'b0);
            wait_tx_done(c0, 1500);
            check("echo_latency", ((tx_done_cyc - rx_done_cyc) >= 630) && ((tx_done_cyc - rx_done_cyc) <= 645), 1);
            check("echo_tx_busy_low", tx_busy, 0);
            repeat (20) @(negedge clk);
        end
        loop_en = 1'b0;

        // second request while busy is dropped
        c0 = tx_done_cnt;
        @(negedge clk);
        tb_tx_data  = 8'hA5;
        tb_tx_start = 1'b1;
        txq.push_back(8'hA5);
        @(negedge clk);
        tb_tx_start = 1'b0;
        check("tx_busy_set", tx_busy, 1);
        repeat (200) @(negedge clk);
        tb_tx_data  = 8'h5A;
        tb_tx_start = 1'b1;
        @(negedge clk);
        tb_tx_start = 1'b0;
        wait_tx_done(c0, 1000);
        repeat (300) @(negedge clk);
        check("tx_done_single", tx_done_cnt, c0 + 1);
        check("tx_line_idle", tx, 1);

        // short low pulse on rx
        c0 = rx_done_cnt;
        @(negedge clk);
        rx = 1'b0;
        #100;
        check("glitch_busy", rx_busy, 1);
        rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        check("glitch_busy_clr", rx_busy, 0);
        check("glitch_no_done", rx_done_cnt, c0);

        // stop bit sampled low
        c0 = rx_done_cnt;
`ifdef UART_FRAME_ERR_EN
        send_rx(8'h55, 1'b0, 1'b0);
        check("ferr_set", rx_frame_err, 1);
        check("ferr_no_done", rx_done_cnt, c0);
        check("ferr_data_kept", rx_data, 8'h30);
`else
        rxq.push_back(8'h55);
        send_rx(8'h55, 1'b0, 1'b0);
        check("bad_stop_done", rx_done_cnt, c0 + 1);
        check("bad_stop_data", rx_data, 8'h55);
`endif
        repeat (BIT_CLKS) @(negedge clk);
        check("bad_stop_busy_clr", rx_busy, 0);
`ifdef UART_FRAME_ERR_EN
        check("ferr_held", rx_frame_err, 1);
`endif

        // next valid frame
        rxq.push_back(8'hC3);
        send_rx(8'hC3, 1'b1, 1'b1);
        check("rx_data_c3", rx_data, 8'hC3);
`ifdef UART_FRAME_ERR_EN
        check("ferr_cleared", rx_frame_err, 0);
`endif

        repeat (100) @(negedge clk);
        check("rxq_empty", rxq.size(), 0);
        check("txq_empty", txq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
